// File: rtl/exp_interp_unit_pkg.sv
// Shared constants and types for the exp(-x) interpolation unit.
package exp_interp_unit_pkg;
    localparam int WIDTH           = 16;
    localparam int DECIMAL_BITS    = 7;
    localparam int ONE             = 1 << DECIMAL_BITS;
    localparam int EXP_ADDR_BITS   = 8;
    localparam int EXP_FRAC_BITS   = 2;
    localparam int EXP_DOMAIN_BITS = EXP_ADDR_BITS + EXP_FRAC_BITS;

    typedef logic [WIDTH-1:0]       word_t;
    // One extra bit so that address 2^EXP_ADDR_BITS (the zero entry) is reachable.
    typedef logic [EXP_ADDR_BITS:0] rom_addr_t;

    typedef struct packed {
        logic [EXP_ADDR_BITS-1:0] addr;
        logic [EXP_FRAC_BITS-1:0] frac;
        logic                     neg;
        logic                     over;
    } s1_t;
endpackage

// File: rtl/exp_interp_unit_rom.sv
// Dual-read combinational exp(-x) table: entry i = round(exp(-i/32) * 128).
// Entries from 178 up, including the extra address 256, are zero.
module exp_rom
    import exp_interp_unit_pkg::*;
(
    input  rom_addr_t addr_a,
    input  rom_addr_t addr_b,
    output word_t     data_a,
    output word_t     data_b
);

    function automatic word_t rom_lookup(input rom_addr_t a);
        logic [7:0] v;
        v = 8'd0;
        case (a) inside
            9'd0:  v = 8'd128; 9'd1:  v = 8'd124; 9'd2:  v = 8'd120; 9'd3:  v = 8'd117;
            9'd4:  v = 8'd113; 9'd5:  v = 8'd109; 9'd6:  v = 8'd106; 9'd7:  v = 8'd103;
            9'd8:  v = 8'd100; 9'd9:  v = 8'd97;  9'd10: v = 8'd94;  9'd11: v = 8'd91;
            9'd12: v = 8'd88;  9'd13: v = 8'd85;  9'd14: v = 8'd83;  9'd15: v = 8'd80;
            9'd16: v = 8'd78;  9'd17: v = 8'd75;  9'd18: v = 8'd73;  9'd19: v = 8'd71;
            9'd20: v = 8'd69;  9'd21: v = 8'd66;  9'd22: v = 8'd64;  9'd23: v = 8'd62;
            9'd24: v = 8'd60;  9'd25: v = 8'd59;  9'd26: v = 8'd57;  9'd27: v = 8'd55;
            9'd28: v = 8'd53;  9'd29: v = 8'd52;  9'd30: v = 8'd50;  9'd31: v = 8'd49;
            9'd32: v = 8'd47;  9'd33: v = 8'd46;  9'd34: v = 8'd44;  9'd35: v = 8'd43;
            9'd36: v = 8'd42;  9'd37: v = 8'd40;  9'd38: v = 8'd39;  9'd39: v = 8'd38;
            9'd40: v = 8'd37;  9'd41: v = 8'd36;  9'd42: v = 8'd34;  9'd43: v = 8'd33;
            9'd44: v = 8'd32;  9'd45: v = 8'd31;  9'd46: v = 8'd30;  9'd47: v = 8'd29;
            9'd48: v = 8'd29;  9'd49: v = 8'd28;  9'd50: v = 8'd27;  9'd51: v = 8'd26;
            9'd52: v = 8'd25;  9'd53: v = 8'd24;  9'd54: v = 8'd24;  9'd55: v = 8'd23;
            9'd56: v = 8'd22;  9'd57: v = 8'd22;  9'd58: v = 8'd21;  9'd59: v = 8'd20;
            9'd60: v = 8'd20;  9'd61: v = 8'd19;  9'd62: v = 8'd18;  9'd63: v = 8'd18;
            9'd64: v = 8'd17;  9'd65: v = 8'd17;  9'd66: v = 8'd16;  9'd67: v = 8'd16;
            9'd68: v = 8'd15;  9'd69: v = 8'd15;  9'd70: v = 8'd14;  9'd71: v = 8'd14;
            9'd72: v = 8'd13;  9'd73: v = 8'd13;  9'd74: v = 8'd13;  9'd75: v = 8'd12;
            9'd76: v = 8'd12;  9'd77: v = 8'd12;  9'd78: v = 8'd11;  9'd79: v = 8'd11;
            9'd80: v = 8'd11;  9'd81: v = 8'd10;  9'd82: v = 8'd10;  9'd83: v = 8'd10;
            9'd84: v = 8'd9;   9'd85: v = 8'd9;   9'd86: v = 8'd9;
            [9'd87:9'd90]:   v = 8'd8;
            [9'd91:9'd95]:   v = 8'd7;
            [9'd96:9'd100]:  v = 8'd6;
            [9'd101:9'd107]: v = 8'd5;
            [9'd108:9'd115]: v = 8'd4;
            [9'd116:9'd125]: v = 8'd3;
            [9'd126:9'd142]: v = 8'd2;
            [9'd143:9'd177]: v = 8'd1;
            default:         v = 8'd0;
        endcase
        return word_t'(v);
    endfunction

    // Both read ports decode the same table.
    always_comb begin
        data_a = rom_lookup(addr_a);
        data_b = rom_lookup(addr_b);
    end

endmodule

// File: rtl/exp_interp_unit.sv
// Three-stage exp(-x) evaluator: split/flag, table read, interpolate/clamp.
// All stages advance together; a stalled output freezes the whole pipe.
module exp_interp_unit
    import exp_interp_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_x,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_range,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int PW = WIDTH + EXP_FRAC_BITS + 2;
    localparam logic signed [PW-1:0] RND  = PW'(1 << (EXP_FRAC_BITS - 1));
    localparam logic signed [PW-1:0] RONE = PW'(ONE);

    logic      w_adv;
    s1_t       r_s1;
    logic      r_v1, r_v2;
    word_t     r_l0, r_l1;
    logic [EXP_FRAC_BITS-1:0] r_f2;
    logic      r_neg2, r_over2;
    rom_addr_t w_addr_a, w_addr_b;
    word_t     w_rom_a, w_rom_b;
    logic signed [PW-1:0] w_l0, w_l1, w_fx, w_d, w_prod, w_step, w_sum;
    word_t     w_y;

    assign w_adv    = !(out_valid && !out_ready);
    assign in_ready = w_adv;

    // S1: split argument into table address and fraction, flag out-of-domain values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
        end else if (w_adv) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s1.addr <= in_x[EXP_FRAC_BITS +: EXP_ADDR_BITS];
                r_s1.frac <= in_x[EXP_FRAC_BITS-1:0];
                r_s1.neg  <= in_x[WIDTH-1];
                r_s1.over <= !in_x[WIDTH-1] && (in_x[WIDTH-2:EXP_DOMAIN_BITS] != '0);
            end
        end
    end

    assign w_addr_a = {1'b0, r_s1.addr};
    assign w_addr_b = w_addr_a + rom_addr_t'(1);

    exp_rom u_rom (
        .addr_a (w_addr_a),
        .addr_b (w_addr_b),
        .data_a (w_rom_a),
        .data_b (w_rom_b)
    );

    // S2: capture both neighbouring table entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_l0    <= '0;
            r_l1    <= '0;
            r_f2    <= '0;
            r_neg2  <= 1'b0;
            r_over2 <= 1'b0;
        end else if (w_adv) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_l0    <= w_rom_a;
                r_l1    <= w_rom_b;
                r_f2    <= r_s1.frac;
                r_neg2  <= r_s1.neg;
                r_over2 <= r_s1.over;
            end
        end
    end

    assign w_l0   = {{(PW-WIDTH){1'b0}}, r_l0};
    assign w_l1   = {{(PW-WIDTH){1'b0}}, r_l1};
    assign w_fx   = {{(PW-EXP_FRAC_BITS){1'b0}}, r_f2};
    assign w_d    = w_l1 - w_l0;
    assign w_prod = w_d * w_fx;
    assign w_step = (w_prod + RND) >>> EXP_FRAC_BITS;
    assign w_sum  = w_l0 + w_step;

    // Saturate the interpolated value to [0, ONE].
    always_comb begin
        w_y = w_sum[WIDTH-1:0];
        if (w_sum[PW-1])
            w_y = '0;
        else if (w_sum > RONE)
            w_y = WIDTH'(ONE);
    end

    // S3: output register with domain clamping; held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_range <= 1'b0;
        end else if (w_adv) begin
            out_valid <= r_v2;
            if (r_v2) begin
                if (r_neg2) begin
                    out_y     <= WIDTH'(ONE);
                    out_range <= 1'b1;
                end else if (r_over2) begin
                    out_y     <= '0;
                    out_range <= 1'b1;
                end else begin
                    out_y     <= w_y;
                    out_range <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_exp_interp_unit.sv
// Self-checking bench for exp_interp_unit: directed cases plus randomized
// traffic against a real-arithmetic exp(-x) model with a result queue.
module tb_exp_interp_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_x;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_y;
    logic        out_range;
    logic        out_valid;
    logic        out_ready;

    typedef struct { int y; int r; } res_t;

    int   n_total = 0;
    int   n_bad   = 0;
    int   rom [0:256];
    res_t exp_q [$];

    exp_interp_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_x      (in_x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_y     (out_y),
        .out_range (out_range),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] x);
        res_t res;
        int xs, a, f, d, t, q, y;
        xs = int'($signed(x));
        if (xs < 0) begin
            res.y = 128; res.r = 1;
        end else if (xs >= 1024) begin
            res.y = 0; res.r = 1;
        end else begin
            a = xs / 4;
            f = xs % 4;
            d = rom[a+1] - rom[a];
            t = d * f + 2;
            q = (t >= 0) ? t / 4 : -((3 - t) / 4);
            y = rom[a] + q;
            if (y < 0) y = 0;
            if (y > 128) y = 128;
            res.y = y; res.r = 0;
        end
        return res;
    endfunction

    // One cycle of handshake traffic, scored against the queue.
    task automatic step(input logic v, input logic [15:0] x, input logic rdy);
        res_t e;
        @(negedge clk);
        in_valid  = v;
        in_x      = x;
        out_ready = rdy;
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_out", 1, 0);
            end else begin
                check_val("out_y", int'(out_y), exp_q[0].y);
                check_val("out_range", int'(out_range), exp_q[0].r);
                if (out_ready) e = exp_q.pop_front();
            end
        end
        check_val("in_ready", int'(in_ready), (out_valid && !out_ready) ? 0 : 1);
        if (in_valid && in_ready) exp_q.push_back(model(x));
    endtask

    task automatic single(input logic [15:0] x, input int ey, input int er, input string tag);
        @(negedge clk);
        in_valid  = 1'b1;
        in_x      = x;
        out_ready = 1'b1;
        #1;
        check_val({tag, "_in_ready"}, int'(in_ready), 1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check_val({tag, "_valid"}, int'(out_valid), (k == 3) ? 1 : 0);
        end
        check_val({tag, "_y"}, int'(out_y), ey);
        check_val({tag, "_range"}, int'(out_range), er);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            step(1'b0, 16'd0, 1'b1);
            guard++;
        end
        check_val(tag, exp_q.size(), 0);
    endtask

    function automatic logic [15:0] rand_x();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      return 16'($urandom_range(32768, 65535));
        else if (sel == 1) return 16'($urandom_range(1024, 32767));
        else               return 16'($urandom_range(0, 1023));
    endfunction

    initial begin
        for (int i = 0; i < 256; i++)
            rom[i] = $rtoi($exp(-real'(i) / 32.0) * 128.0 + 0.5);
        rom[256] = 0;

        rst_n = 1'b0; in_valid = 1'b0; in_x = 16'd0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_out_y", int'(out_y), 0);
        check_val("rst_out_range", int'(out_range), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_val("rst_in_ready", int'(in_ready), 1);

        single(16'd0,    128, 0, "x0");
        single(16'd128,  47,  0, "x128");
        single(16'd1,    127, 0, "x1");
        single(16'hFD80, 128, 1, "xneg640");
        single(16'd1024, 0,   1, "x1024");
        single(16'd1023, 0,   0, "x1023");

        // Back-to-back stream: results must appear on consecutive cycles.
        step(1'b1, 16'd0, 1'b1);
        step(1'b1, 16'd128, 1'b1);
        step(1'b1, 16'd1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 16'd0, 1'b1);
            check_val("b2b_valid", int'(out_valid), 1);
        end
        step(1'b0, 16'd0, 1'b1);
        check_val("b2b_done", int'(out_valid), 0);
        check_val("b2b_queue", exp_q.size(), 0);

        // Five-cycle downstream stall in mid-stream.
        step(1'b1, 16'd5, 1'b1);
        step(1'b1, 16'd40, 1'b1);
        step(1'b1, 16'd200, 1'b1);
        step(1'b1, 16'd701, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 16'd77 + 16'(k), 1'b0);
            check_val("stall_in_ready", int'(in_ready), 0);
            check_val("stall_out_valid", int'(out_valid), 1);
        end
        step(1'b1, 16'd350, 1'b1);
        step(1'b1, 16'd1022, 1'b1);
        drain("stall_drain");

        // Reset with results in flight discards them.
        step(1'b1, 16'd10, 1'b1);
        step(1'b1, 16'd20, 1'b1);
        step(1'b1, 16'd30, 1'b1);
        step(1'b0, 16'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", int'(out_valid), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 16'd0, 1'b1);
            check_val("midrst_no_stale", int'(out_valid), 0);
        end

        // Randomized traffic with random back-pressure.
        for (int k = 0; k < 600; k++)
            step(1'($urandom_range(0, 3) != 0), rand_x(), 1'($urandom_range(0, 3) != 0));
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
